// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the controller state encoding, the control-output bundle and its canned values.
package pipe_hazard_ctrl_pkg;

    localparam int REG_IDX_W  = 4;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    typedef struct packed {
        logic freeze_pc;
        logic freeze_if_id;
        logic freeze_id_exe;
        logic freeze_exe_mem;
        logic bubble_mem_wb;
        logic flush_if_id;
        logic flush_id_exe;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_t CTRL_MEM_STALL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_FLUSH     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_HAZARD    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // A register dependency exists only when the producing stage actually writes back.
    function automatic logic idx_match(
        input logic [REG_IDX_W-1:0] src,
        input logic [REG_IDX_W-1:0] dest,
        input logic                 wb_en
    );
        return wb_en & (src == dest);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational read-after-write hazard detector for the ID stage.
// With forwarding enabled only a load in EXE can still cause a stall.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] src1,
    input  logic [REG_IDX_W-1:0] src2,
    input  logic                 two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 exe_wb_en,
    input  logic                 mem_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic                 fwd_en,
    output logic                 hazard
);

    logic src1_exe_s;
    logic src1_mem_s;
    logic src2_exe_s;
    logic src2_mem_s;

    assign src1_exe_s = idx_match(src1, exe_dest, exe_wb_en);
    assign src1_mem_s = idx_match(src1, mem_dest, mem_wb_en);
    assign src2_exe_s = two_src & idx_match(src2, exe_dest, exe_wb_en);
    assign src2_mem_s = two_src & idx_match(src2, mem_dest, mem_wb_en);

    // Select the hazard rule for the current forwarding mode
    always_comb begin
        hazard = 1'b0;
        if (fwd_en) begin
            hazard = exe_mem_r_en & (src1_exe_s | src2_exe_s);
        end else begin
            hazard = src1_exe_s | src1_mem_s | src2_exe_s | src2_mem_s;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, memory-wait tracking with timeout,
// sticky error flag and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_IDX_W-1:0]   src1,
    input  logic [REG_IDX_W-1:0]   src2,
    input  logic                   two_src,
    input  logic [REG_IDX_W-1:0]   exe_dest,
    input  logic [REG_IDX_W-1:0]   mem_dest,
    input  logic                   exe_wb_en,
    input  logic                   mem_wb_en,
    input  logic                   exe_mem_r_en,
    input  logic                   fwd_en,
    input  logic                   branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    output logic                   freeze_pc,
    output logic                   freeze_if_id,
    output logic                   flush_if_id,
    output logic                   flush_id_exe,
    output logic                   freeze_id_exe,
    output logic                   freeze_exe_mem,
    output logic                   bubble_mem_wb,
    output logic                   err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [WAIT_CNT_W-1:0]  TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [WAIT_CNT_W-1:0]   wait_cnt_r;
    logic                    err_r;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic                    hazard_s;
    logic                    mem_hold_s;
    logic                    new_wait_s;
    logic                    timeout_s;
    ctrl_t                   ctrl_s;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (v == STALL_MAX) ? v : v + STALL_CNT_W'(1);
    endfunction

    hazard_detect u_hazard_detect (
        .src1         (src1),
        .src2         (src2),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .mem_dest     (mem_dest),
        .exe_wb_en    (exe_wb_en),
        .mem_wb_en    (mem_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .fwd_en       (fwd_en),
        .hazard       (hazard_s)
    );

    assign new_wait_s = (state_r == RUN) & mem_req & ~mem_ready;
    assign timeout_s  = (state_r == MEM_WAIT) & ~mem_ready & (wait_cnt_r == TIMEOUT_C);

    // Memory hold: a fresh unserved request, any cycle still waiting, or the error lock
    always_comb begin
        mem_hold_s = 1'b1;
        case (state_r)
            RUN:      mem_hold_s = mem_req & ~mem_ready;
            MEM_WAIT: mem_hold_s = ~mem_ready;
            ERR:      mem_hold_s = 1'b1;
            default:  mem_hold_s = 1'b1;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = RUN;
        case (state_r)
            RUN: begin
                if (mem_req & ~mem_ready) begin
                    state_nxt_s = MEM_WAIT;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_nxt_s = RUN;
                end else if (wait_cnt_r == TIMEOUT_C) begin
                    state_nxt_s = ERR;
                end else begin
                    state_nxt_s = MEM_WAIT;
                end
            end
            ERR:     state_nxt_s = ERR;
            default: state_nxt_s = RUN;
        endcase
    end

    // Output logic; a memory hold outranks branch flush, which outranks the data hazard
    always_comb begin
        ctrl_s = CTRL_NONE;
        if (!rst) begin
            ctrl_s = CTRL_NONE;
        end else if (mem_hold_s) begin
            ctrl_s = CTRL_MEM_STALL;
        end else if (branch_taken) begin
            ctrl_s = CTRL_FLUSH;
        end else if (hazard_s) begin
            ctrl_s = CTRL_HAZARD;
        end else begin
            ctrl_s = CTRL_NONE;
        end
    end

    // Wait counter: starts at 1 on the stalling request cycle, stops at the limit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= '0;
        end else if (new_wait_s) begin
            wait_cnt_r <= 8'd1;
        end else if (state_r == MEM_WAIT) begin
            if (mem_ready) begin
                wait_cnt_r <= '0;
            end else if (wait_cnt_r != TIMEOUT_C) begin
                wait_cnt_r <= wait_cnt_r + 8'd1;
            end
        end
    end

    // Sticky timeout error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r <= 1'b0;
        end else if (timeout_s) begin
            err_r <= 1'b1;
        end
    end

    // Saturating count of PC-freeze cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= '0;
        end else if (ctrl_s.freeze_pc) begin
            stall_cnt_r <= sat_inc(stall_cnt_r);
        end
    end

    assign freeze_pc      = ctrl_s.freeze_pc;
    assign freeze_if_id   = ctrl_s.freeze_if_id;
    assign freeze_id_exe  = ctrl_s.freeze_id_exe;
    assign freeze_exe_mem = ctrl_s.freeze_exe_mem;
    assign bubble_mem_wb  = ctrl_s.bubble_mem_wb;
    assign flush_if_id    = ctrl_s.flush_if_id;
    assign flush_id_exe   = ctrl_s.flush_id_exe;
    assign err            = err_r;
    assign stall_cnt      = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model, on a default instance and a small one (TIMEOUT=4, 4-bit counter).
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic two_src, exe_wb_en, mem_wb_en, exe_mem_r_en, fwd_en, branch_taken, mem_req, mem_ready;

    logic a_fpc, a_fifid, a_flifid, a_flidexe, a_fidexe, a_fexemem, a_bub, err_a;
    logic b_fpc, b_fifid, b_flifid, b_flidexe, b_fidexe, b_fexemem, b_bub, err_b;
    logic [15:0] stall_a;
    logic [3:0]  stall_b;
    logic [6:0]  ctl_a, ctl_b;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_FRZ   = 7'b1111100;
    localparam logic [6:0] C_FLUSH = 7'b0000011;
    localparam logic [6:0] C_HAZ   = 7'b1100001;

    int   m_mode [2];
    int   m_wait [2];
    logic m_err  [2];
    int   m_stall[2];
    int   m_to   [2] = '{255, 4};
    int   m_max  [2] = '{65535, 15};

    always #5 clk = ~clk;

    assign ctl_a = {a_fpc, a_fifid, a_fidexe, a_fexemem, a_bub, a_flifid, a_flidexe};
    assign ctl_b = {b_fpc, b_fifid, b_fidexe, b_fexemem, b_bub, b_flifid, b_flidexe};

    pipe_hazard_ctrl dut_a (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(a_fpc), .freeze_if_id(a_fifid), .flush_if_id(a_flifid), .flush_id_exe(a_flidexe),
        .freeze_id_exe(a_fidexe), .freeze_exe_mem(a_fexemem), .bubble_mem_wb(a_bub),
        .err(err_a), .stall_cnt(stall_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(4), .STALL_CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .freeze_pc(b_fpc), .freeze_if_id(b_fifid), .flush_if_id(b_flifid), .flush_id_exe(b_flidexe),
        .freeze_id_exe(b_fidexe), .freeze_exe_mem(b_fexemem), .bubble_mem_wb(b_bub),
        .err(err_b), .stall_cnt(stall_b)
    );

    // ---------------- behavioural model ----------------
    function automatic logic ref_hazard();
        logic e1, m1, e2, m2;
        e1 = exe_wb_en && (src1 == exe_dest);
        m1 = mem_wb_en && (src1 == mem_dest);
        e2 = two_src && exe_wb_en && (src2 == exe_dest);
        m2 = two_src && mem_wb_en && (src2 == mem_dest);
        if (fwd_en) return exe_mem_r_en && (e1 || e2);
        return e1 || m1 || e2 || m2;
    endfunction

    function automatic logic [6:0] model_ctl(int i);
        logic waiting;
        if (!rst) return C_NONE;
        if (m_mode[i] == 2) return C_FRZ;
        waiting = (m_mode[i] == 0) ? (mem_req && !mem_ready) : !mem_ready;
        if (waiting) return C_FRZ;
        if (branch_taken) return C_FLUSH;
        if (ref_hazard()) return C_HAZ;
        return C_NONE;
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic [6:0] c;
            c = model_ctl(i);
            if (c[6] && m_stall[i] < m_max[i]) m_stall[i]++;
            if (m_mode[i] == 0) begin
                if (mem_req && !mem_ready) begin
                    m_mode[i] = 1;
                    m_wait[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (mem_ready) m_mode[i] = 0;
                else if (m_wait[i] == m_to[i]) begin
                    m_mode[i] = 2;
                    m_err[i]  = 1'b1;
                end else m_wait[i]++;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_wait[i] = 0; m_err[i] = 1'b0; m_stall[i] = 0;
        end
    endtask

    // ---------------- stimulus plumbing ----------------
    task automatic clear_inputs();
        src1 = 4'd0; src2 = 4'd0; exe_dest = 4'd0; mem_dest = 4'd0;
        two_src = 1'b0; exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        fwd_en = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; branch_taken = 1'b1; mem_req = 1'b1;
        assert_reset();
        tests++; if (ctl_a !== C_NONE) begin fails++; $display("FAIL reset_ctl_a got=%b want=%b", ctl_a, C_NONE); end
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL reset_ctl_b got=%b want=%b", ctl_b, C_NONE); end
        tests++; if ({err_a, err_b} !== 2'b00) begin fails++; $display("FAIL reset_err got=%b want=00", {err_a, err_b}); end
        tests++; if (stall_a !== 16'd0 || stall_b !== 4'd0) begin fails++; $display("FAIL reset_stall got=%0d/%0d want=0/0", stall_a, stall_b); end
        clear_inputs();
        release_reset();
        settle();
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL idle_ctl got=%b want=%b", ctl_b, C_NONE); end
        tick();
    endtask

    task automatic test_hazard_nofwd();
        assert_reset();
        release_reset();
        src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
        settle();
        tests++; if (ctl_b !== C_HAZ || ctl_a !== C_HAZ) begin fails++; $display("FAIL haz_exe got=%b/%b want=%b", ctl_a, ctl_b, C_HAZ); end
        tests++; if (stall_b !== 4'd0) begin fails++; $display("FAIL haz_stall0 got=%0d want=0", stall_b); end
        tick();
        clear_inputs();
        settle();
        tests++; if (stall_b !== 4'd1) begin fails++; $display("FAIL haz_stall1 got=%0d want=1", stall_b); end
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL haz_clear got=%b want=%b", ctl_b, C_NONE); end
        tick();
        two_src = 1'b1; src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1;
        settle();
        tests++; if (ctl_b !== C_HAZ) begin fails++; $display("FAIL haz_src2_mem got=%b want=%b", ctl_b, C_HAZ); end
        tick();
        two_src = 1'b0;
        settle();
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL haz_src2_unused got=%b want=%b", ctl_b, C_NONE); end
        tick();
        clear_inputs();
    endtask

    task automatic test_hazard_fwd();
        fwd_en = 1'b1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b0;
        settle();
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL fwd_noload got=%b want=%b", ctl_b, C_NONE); end
        tick();
        exe_mem_r_en = 1'b1;
        settle();
        tests++; if (ctl_b !== C_HAZ) begin fails++; $display("FAIL fwd_load got=%b want=%b", ctl_b, C_HAZ); end
        tick();
        exe_dest = 4'd4; mem_dest = 4'd3; mem_wb_en = 1'b1;
        settle();
        tests++; if (ctl_b !== C_NONE) begin fails++; $display("FAIL fwd_mem_ignored got=%b want=%b", ctl_b, C_NONE); end
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_priority();
        src1 = 4'd5; exe_dest = 4'd5; exe_wb_en = 1'b1; branch_taken = 1'b1;
        settle();
        tests++; if (ctl_b !== C_FLUSH || ctl_a !== C_FLUSH) begin fails++; $display("FAIL branch_over_hazard got=%b/%b want=%b", ctl_a, ctl_b, C_FLUSH); end
        tick();
        clear_inputs();
    endtask

    task automatic test_mem_wait_branch();
        assert_reset();
        release_reset();
        mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            tests++; if (ctl_b !== C_FRZ || ctl_a !== C_FRZ) begin fails++; $display("FAIL memwait_frz%0d got=%b/%b want=%b", k, ctl_a, ctl_b, C_FRZ); end
            tick();
        end
        mem_ready = 1'b1;
        settle();
        tests++; if (ctl_b !== C_FLUSH || ctl_a !== C_FLUSH) begin fails++; $display("FAIL memwait_release got=%b/%b want=%b", ctl_a, ctl_b, C_FLUSH); end
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        settle();
        tests++; if (ctl_b !== C_FLUSH) begin fails++; $display("FAIL memwait_back_in_run got=%b want=%b", ctl_b, C_FLUSH); end
        tests++; if (stall_b !== 4'd3 || stall_a !== 16'd3) begin fails++; $display("FAIL memwait_stall got=%0d/%0d want=3/3", stall_a, stall_b); end
        tick();
        clear_inputs();
    endtask

    task automatic test_timeout();
        assert_reset();
        release_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            tests++; if (ctl_b !== C_FRZ || err_b !== 1'b0) begin fails++; $display("FAIL to_wait%0d got=%b err=%b want=%b err=0", k, ctl_b, err_b, C_FRZ); end
            tick();
        end
        settle();
        tests++; if (err_b !== 1'b1 || err_a !== 1'b0) begin fails++; $display("FAIL to_err got=%b/%b want=0/1", err_a, err_b); end
        tick();
        mem_req = 1'b0; mem_ready = 1'b1; branch_taken = 1'b1;
        settle();
        tests++; if (ctl_b !== C_FRZ || err_b !== 1'b1) begin fails++; $display("FAIL to_err_sticky got=%b err=%b want=%b err=1", ctl_b, err_b, C_FRZ); end
        tests++; if (ctl_a !== C_FLUSH) begin fails++; $display("FAIL to_default_release got=%b want=%b", ctl_a, C_FLUSH); end
        tick();
        assert_reset();
        tests++; if (err_b !== 1'b0 || ctl_b !== C_NONE) begin fails++; $display("FAIL to_reset_clear got=%b err=%b want=%b err=0", ctl_b, err_b, C_NONE); end
        clear_inputs();
        release_reset();
    endtask

    task automatic test_stall_saturate();
        assert_reset();
        release_reset();
        src1 = 4'd9; exe_dest = 4'd9; exe_wb_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            settle();
            tests++; if (stall_b !== 4'((k > 15) ? 15 : k)) begin fails++; $display("FAIL sat_cnt%0d got=%0d want=%0d", k, stall_b, (k > 15) ? 15 : k); end
            tick();
        end
        settle();
        tests++; if (stall_b !== 4'd15 || stall_a !== 16'd20) begin fails++; $display("FAIL sat_final got=%0d/%0d want=20/15", stall_a, stall_b); end
        clear_inputs();
        mem_req = 1'b1;
        tick();
        tick();
        assert_reset();
        tests++; if (ctl_b !== C_NONE || ctl_a !== C_NONE) begin fails++; $display("FAIL midwait_reset_ctl got=%b/%b want=%b", ctl_a, ctl_b, C_NONE); end
        tests++; if (stall_b !== 4'd0 || err_b !== 1'b0) begin fails++; $display("FAIL midwait_reset_regs got=%0d err=%b want=0 err=0", stall_b, err_b); end
        mem_req = 1'b0; branch_taken = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++; if (ctl_b !== C_FLUSH || ctl_a !== C_FLUSH) begin fails++; $display("FAIL midwait_run_after got=%b/%b want=%b", ctl_a, ctl_b, C_FLUSH); end
        tick();
        clear_inputs();
    endtask

    task automatic test_random();
        assert_reset();
        release_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            src1 = 4'($urandom_range(0, 3)); src2 = 4'($urandom_range(0, 3));
            exe_dest = 4'($urandom_range(0, 3)); mem_dest = 4'($urandom_range(0, 3));
            two_src = 1'($urandom_range(0, 1)); exe_wb_en = 1'($urandom_range(0, 1));
            mem_wb_en = 1'($urandom_range(0, 1)); exe_mem_r_en = 1'($urandom_range(0, 1));
            fwd_en = 1'($urandom_range(0, 1)); branch_taken = ($urandom_range(0, 3) == 0);
            mem_req = ($urandom_range(0, 2) == 0); mem_ready = 1'($urandom_range(0, 1));
            if (cyc % 75 == 74) begin
                assert_reset();
                tests++; if (ctl_a !== C_NONE || ctl_b !== C_NONE) begin fails++; $display("FAIL rnd_reset%0d got=%b/%b want=%b", cyc, ctl_a, ctl_b, C_NONE); end
                release_reset();
            end else begin
                settle();
                tests++; if (ctl_a !== model_ctl(0)) begin fails++; $display("FAIL rnd_ctl_a%0d got=%b want=%b", cyc, ctl_a, model_ctl(0)); end
                tests++; if (ctl_b !== model_ctl(1)) begin fails++; $display("FAIL rnd_ctl_b%0d got=%b want=%b", cyc, ctl_b, model_ctl(1)); end
                tests++; if (err_a !== m_err[0] || err_b !== m_err[1]) begin fails++; $display("FAIL rnd_err%0d got=%b/%b want=%b/%b", cyc, err_a, err_b, m_err[0], m_err[1]); end
                tests++; if (stall_a !== 16'(m_stall[0]) || stall_b !== 4'(m_stall[1])) begin fails++; $display("FAIL rnd_stall%0d got=%0d/%0d want=%0d/%0d", cyc, stall_a, stall_b, m_stall[0], m_stall[1]); end
                tick();
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_hazard_nofwd();
        test_hazard_fwd();
        test_branch_priority();
        test_mem_wait_branch();
        test_timeout();
        test_stall_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, memory-wait cycle limit (1..255) before the error state.
REQ-002 Parameter STALL_CNT_W, default 16, width of the stall-cycle counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 src1, src2  in  4 each  ID-stage source register indices.
REQ-006 two_src  in  1  ID instruction reads src2.
REQ-007 exe_dest, mem_dest  in  4 each  destination indices in EXE and MEM stages.
REQ-008 exe_wb_en, mem_wb_en  in  1 each  writeback enables in EXE and MEM.
REQ-009 exe_mem_r_en  in  1  EXE instruction is a load.
REQ-010 fwd_en  in  1  forwarding unit active.
REQ-011 branch_taken  in  1  EXE-stage branch resolved taken.
REQ-012 mem_req, mem_ready  in  1 each  MEM-stage memory access request and completion.
REQ-013 freeze_pc, freeze_if_id  out  1 each  hold PC and IF/ID register.
REQ-014 flush_if_id, flush_id_exe  out  1 each  clear IF/ID and ID/EXE to a bubble.
REQ-015 freeze_id_exe, freeze_exe_mem  out  1 each  hold ID/EXE and EXE/MEM.
REQ-016 bubble_mem_wb  out  1  load a bubble into MEM/WB.
REQ-017 err  out  1  sticky memory-timeout error.
REQ-018 stall_cnt  out  STALL_CNT_W  saturating count of cycles with freeze_pc high.

Function
REQ-019 Hazard, fwd_en=0: (src1==exe_dest & exe_wb_en) | (src1==mem_dest & mem_wb_en) | (two_src & the same terms on src2).
REQ-020 Hazard, fwd_en=1: exe_mem_r_en & exe_wb_en & (src1==exe_dest | (two_src & src2==exe_dest)); mem_dest ignored.
REQ-021 FSM states RUN, MEM_WAIT, ERR; all outputs combinational from state and inputs, except err and stall_cnt (registered).
REQ-022 RUN, mem_req & !mem_ready: freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem, bubble_mem_wb high same cycle; no flush; next state MEM_WAIT; wait_cnt <= 1.
REQ-023 RUN, no memory stall, branch_taken: flush_if_id and flush_id_exe high; no freeze; hazard ignored.
REQ-024 RUN, no memory stall, no branch, hazard: freeze_pc, freeze_if_id, flush_id_exe high.
REQ-025 RUN, none of the above: all control outputs low.
REQ-026 MEM_WAIT, mem_ready=0: same five freeze/bubble outputs as REQ-022; flushes suppressed even if branch_taken; wait_cnt increments.
REQ-027 MEM_WAIT, mem_ready=1: outputs evaluated exactly as in RUN (REQ-023..025), so a pending branch flush applies on the release cycle; next state RUN.
REQ-028 MEM_WAIT, mem_ready=0 and wait_cnt==TIMEOUT: next state ERR; err <= 1.
REQ-029 ERR: all five freeze/bubble outputs high, flushes low, ignores all inputs; exit only by reset.
REQ-030 stall_cnt increments by 1 on each cycle freeze_pc is high; holds at all-ones.
REQ-031 mem_req low in RUN never enters MEM_WAIT, regardless of mem_ready.

Reset
REQ-032 rst low asynchronously forces state RUN, wait_cnt 0, err 0, stall_cnt 0.
REQ-033 During reset all control outputs are low.
REQ-034 Reset asserted in MEM_WAIT or ERR aborts the wait; the first cycle after release evaluates as RUN.

Structure
REQ-035 Shared package holds the state enum (RUN, MEM_WAIT, ERR) and the register-index width constant (4).
REQ-036 One sub-module, hazard_detect, is purely combinational and implements REQ-019/020.
REQ-037 FSM, wait counter, error flag and stall counter live in pipe_hazard_ctrl.

Verification
REQ-038 fwd_en=0, src1=3, exe_dest=3, exe_wb_en=1, no mem/branch -> freeze_pc=freeze_if_id=flush_id_exe=1 that cycle; stall_cnt 0->1.
REQ-039 fwd_en=1, same as REQ-038 with exe_mem_r_en=0 -> no stall; with exe_mem_r_en=1 -> stall per REQ-024.
REQ-040 hazard and branch_taken together in RUN -> only flush_if_id=flush_id_exe=1, freeze_pc=0.
REQ-041 mem_req=1, mem_ready low 3 cycles, branch_taken=1 throughout, then ready -> freezes 3 cycles, no flush; release cycle flush_if_id=flush_id_exe=1; state RUN; stall_cnt +3.
REQ-042 TIMEOUT=4, mem_req=1, mem_ready=0 held -> ERR after 4 wait cycles; err=1 sticky; mem_ready=1 has no effect; rst low clears.
REQ-043 STALL_CNT_W=4, 20 continuous hazard cycles -> stall_cnt saturates at 15; rst pulse mid-MEM_WAIT -> all outputs low immediately, RUN after release.
